// File: rtl/dmem_axi_master_pkg.sv
// AXI4 channel payload types, protocol constants and FSM states shared by the
// DMEM-to-AXI bridge and anything that binds to its ports.
package dmem_axi_master_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_DATA_BITS-1:0] data;
        logic [AXI_STRB_BITS-1:0] strb;
        logic                     last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0] id;
        logic [1:0]             resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_DATA_BITS-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } axi_r_t;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WR_ADDR_DATA = 3'd1,
        S_WR_RESP      = 3'd2,
        S_RD_ADDR      = 3'd3,
        S_RD_DATA      = 3'd4,
        S_DONE         = 3'd5
    } dmem_axi_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/dmem_axi_master.sv
// Turns each held CPU DMEM request into one single-beat AXI4 transaction and
// stalls the pipeline until the response has been consumed.
//
// Handshake rule on every AXI channel: a transfer happens on the rising ACLK
// edge where valid and ready are both 1; once raised, a valid stays high with
// a stable payload until that edge, and never depends combinationally on the
// matching ready.
module dmem_axi_master
    import dmem_axi_master_pkg::*;
#(
    parameter logic [3:0] ID_VAL = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic                dmem_ren,
    input  logic                dmem_wen,
    input  logic [DATA_W/8-1:0] dmem_wstrb,
    input  logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                stall_o,
    output logic                bus_err_o,
    output axi_aw_t             aw_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output axi_w_t              w_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  axi_b_t              b_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output axi_ar_t             ar_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  axi_r_t              r_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output dmem_axi_state_e     dbg_state_o
);

    dmem_axi_state_e     state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                err_q, err_d;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        bready_o  = 1'b0;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                err_d     = 1'b0;
                // A write wins over a simultaneous read request.
                if (dmem_wen) begin
                    addr_d  = dmem_addr;
                    wdata_d = dmem_wdata;
                    wstrb_d = dmem_wstrb;
                    state_d = S_WR_ADDR_DATA;
                end else if (dmem_ren) begin
                    addr_d  = dmem_addr;
                    state_d = S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: begin
                // AW and W complete independently; move on once both are done.
                awvalid_o = !aw_done_q;
                wvalid_o  = !w_done_q;
                aw_done_d = aw_done_q | awready_i;
                w_done_d  = w_done_q | wready_i;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    err_d   = resp_is_err(b_i.resp);
                    state_d = S_DONE;
                end
            end
            S_RD_ADDR: begin
                arvalid_o = 1'b1;
                if (arready_i) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    rdata_d = r_i.data;
                    err_d   = resp_is_err(r_i.resp);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign aw_o.id    = ID_VAL;
    assign aw_o.addr  = addr_q;
    assign aw_o.len   = 8'd0;
    assign aw_o.size  = SIZE_WORD;
    assign aw_o.burst = BURST_INCR;

    assign ar_o.id    = ID_VAL;
    assign ar_o.addr  = addr_q;
    assign ar_o.len   = 8'd0;
    assign ar_o.size  = SIZE_WORD;
    assign ar_o.burst = BURST_INCR;

    assign w_o.data = wdata_q;
    assign w_o.strb = wstrb_q;
    assign w_o.last = 1'b1;

    // DONE is the one cycle the CPU sees the request released.
    assign stall_o     = (dmem_ren | dmem_wen) & (state_q != S_DONE);
    assign bus_err_o   = (state_q == S_DONE) & err_q;
    assign dmem_rdata  = rdata_q;
    assign dbg_state_o = state_q;

    // Only one transaction is ever outstanding, so response IDs carry no information.
    logic unused_ok;
    assign unused_ok = ^{b_i.id, r_i.id, r_i.last};

endmodule

// File: tb/tb_dmem_axi_master.sv
// Randomized bench for dmem_axi_master: a reactive AXI slave with programmable
// wait states, a transaction-level expectation queue and a negedge monitor.
module tb_dmem_axi_master;
  import dmem_axi_master_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [31:0]     dmem_addr = '0;
  logic            dmem_ren = 1'b0;
  logic            dmem_wen = 1'b0;
  logic [3:0]      dmem_wstrb = '0;
  logic [31:0]     dmem_wdata = '0;
  logic [31:0]     dmem_rdata;
  logic            stall_o, bus_err_o;
  axi_aw_t         aw_o;
  logic            awvalid_o, awready_i;
  axi_w_t          w_o;
  logic            wvalid_o, wready_i;
  axi_b_t          b_i;
  logic            bvalid_i, bready_o;
  axi_ar_t         ar_o;
  logic            arvalid_o, arready_i;
  axi_r_t          r_i;
  logic            rvalid_i, rready_o;
  dmem_axi_state_e dbg_state_o;

  // slave behaviour for the transaction in flight
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;

  // scoreboard
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  logic [36:0] exp_w_q[$];
  exp_t        exp_done_q[$];
  logic [31:0] model_rdata;
  int          stall_cnt;
  int          checks = 0;
  int          failures = 0;

  dmem_axi_master #(.ID_VAL(4'd1), .ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .dmem_addr(dmem_addr), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .bus_err_o(bus_err_o),
    .aw_o(aw_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .w_o(w_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .b_i(b_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .ar_o(ar_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .r_i(r_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic axi_aw_t exp_ax(input logic [31:0] a);
    axi_aw_t x;
    x.id = 4'd1; x.addr = a; x.len = 8'd0; x.size = 3'b010; x.burst = 2'b01;
    return x;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- reactive AXI slave ----------------
  initial begin
    int cnt;
    cnt = 0; awready_i = 1'b0;
    forever begin
      @(negedge ACLK);
      awready_i = 1'b0;
      if (!ARESETn) cnt = 0;
      else if (awvalid_o) begin
        if (cnt >= aw_wait) begin awready_i = 1'b1; cnt = 0; end
        else cnt++;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0; wready_i = 1'b0;
    forever begin
      @(negedge ACLK);
      wready_i = 1'b0;
      if (!ARESETn) cnt = 0;
      else if (wvalid_o) begin
        if (cnt >= w_wait) begin wready_i = 1'b1; cnt = 0; end
        else cnt++;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0; bvalid_i = 1'b0; b_i = '0;
    forever begin
      @(negedge ACLK);
      bvalid_i = 1'b0;
      if (!ARESETn) cnt = 0;
      else if (bready_o) begin
        if (cnt >= b_wait) begin
          bvalid_i = 1'b1; b_i.id = 4'd1; b_i.resp = b_resp; cnt = 0;
        end else cnt++;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0; arready_i = 1'b0;
    forever begin
      @(negedge ACLK);
      arready_i = 1'b0;
      if (!ARESETn) cnt = 0;
      else if (arvalid_o) begin
        if (cnt >= ar_wait) begin arready_i = 1'b1; cnt = 0; end
        else cnt++;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0; rvalid_i = 1'b0; r_i = '0;
    forever begin
      @(negedge ACLK);
      rvalid_i = 1'b0;
      if (!ARESETn) cnt = 0;
      else if (rready_o) begin
        if (cnt >= r_wait) begin
          rvalid_i = 1'b1; r_i.id = 4'd1; r_i.data = r_data;
          r_i.resp = r_resp; r_i.last = 1'b1; cnt = 0;
        end else cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t        e;
    logic        is_done;
    logic        ar_pend, aw_pend, w_pend;
    axi_ar_t     prev_ar;
    axi_aw_t     prev_aw;
    axi_w_t      prev_w;
    ar_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
    prev_ar = '0; prev_aw = '0; prev_w = '0;
    forever begin
      @(negedge ACLK); #1;
      if (!ARESETn) begin
        ar_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
        continue;
      end
      if (stall_o) stall_cnt++;
      is_done = (dmem_ren || dmem_wen) && !stall_o;
      if (is_done) begin
        if (exp_done_q.size() == 0) check("unexpected_release", 64'd1, 64'd0);
        else begin
          e = exp_done_q.pop_front();
          check("rdata_at_release", 64'(dmem_rdata), 64'(e.rdata));
          check("bus_err_at_release", 64'(bus_err_o), 64'(e.err));
          check("stall_cycles", 64'(stall_cnt), 64'(e.lat));
        end
        stall_cnt = 0;
      end else if (bus_err_o) begin
        check("bus_err_outside_release", 64'(bus_err_o), 64'd0);
      end
      if (bready_o && (awvalid_o || wvalid_o)) check("bready_before_aw_w_done", 64'd1, 64'd0);

      if (ar_pend) begin
        check("arvalid_held", 64'(arvalid_o), 64'd1);
        check("ar_stable", 64'(ar_o), 64'(prev_ar));
      end
      if (aw_pend) begin
        check("awvalid_held", 64'(awvalid_o), 64'd1);
        check("aw_stable", 64'(aw_o), 64'(prev_aw));
      end
      if (w_pend) begin
        check("wvalid_held", 64'(wvalid_o), 64'd1);
        check("w_stable", 64'(w_o), 64'(prev_w));
      end

      if (arvalid_o && arready_i) begin
        if (exp_ar_q.size() == 0) check("unexpected_ar", 64'd1, 64'd0);
        else check("ar_beat", 64'(ar_o), 64'(exp_ax(exp_ar_q.pop_front())));
      end
      if (awvalid_o && awready_i) begin
        if (exp_aw_q.size() == 0) check("unexpected_aw", 64'd1, 64'd0);
        else check("aw_beat", 64'(aw_o), 64'(exp_ax(exp_aw_q.pop_front())));
      end
      if (wvalid_o && wready_i) begin
        if (exp_w_q.size() == 0) check("unexpected_w", 64'd1, 64'd0);
        else check("w_beat", 64'(w_o), 64'(exp_w_q.pop_front()));
      end

      ar_pend = arvalid_o && !arready_i; prev_ar = ar_o;
      aw_pend = awvalid_o && !awready_i; prev_aw = aw_o;
      w_pend  = wvalid_o && !wready_i;   prev_w  = w_o;
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 just after the release cycle.
  task automatic run_req(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_t e;
    int   n;
    if (wr) begin
      exp_aw_q.push_back(addr);
      exp_w_q.push_back({wdata, wstrb, 1'b1});
      e.err = (b_resp != 2'b00);
      e.lat = 3 + imax(aw_wait, w_wait) + b_wait;
    end else begin
      exp_ar_q.push_back(addr);
      model_rdata = r_data;
      e.err = (r_resp != 2'b00);
      e.lat = 3 + ar_wait + r_wait;
    end
    e.rdata = model_rdata;
    exp_done_q.push_back(e);
    dmem_wen = wr; dmem_ren = rd; dmem_addr = addr;
    dmem_wdata = wdata; dmem_wstrb = wstrb;
    n = 0;
    do begin @(negedge ACLK); n++; end while (stall_o && n < 200);
    if (stall_o) check("request_timeout", 64'd1, 64'd0);
    @(posedge ACLK); #1;
    dmem_wen = 1'b0; dmem_ren = 1'b0;
  endtask

  task automatic set_waits(input int aw, input int w, input int b, input int ar, input int r);
    aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
  endtask

  initial begin
    int n;
    int kind;
    logic [31:0] a;
    model_rdata = '0; stall_cnt = 0;
    set_waits(0, 0, 0, 0, 0);
    b_resp = 2'b00; r_resp = 2'b00; r_data = '0;

    // reset values
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_state", 64'(dbg_state_o), 64'(S_IDLE));
    check("rst_valids", 64'({awvalid_o, wvalid_o, arvalid_o}), 64'd0);
    check("rst_readies", 64'({bready_o, rready_o}), 64'd0);
    check("rst_rdata", 64'(dmem_rdata), 64'd0);
    check("rst_bus_err", 64'(bus_err_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // zero-wait read
    r_data = 32'hDEAD_BEEF;
    run_req(1'b0, 1'b1, 32'h0000_1004, 32'h0, 4'h0);

    // write with WREADY two cycles after AWREADY
    set_waits(0, 2, 0, 0, 0);
    run_req(1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'b0011);

    // ARREADY held low five cycles
    set_waits(0, 0, 0, 5, 0);
    r_data = 32'hCAFE_0001;
    run_req(1'b0, 1'b1, 32'h0000_3008, 32'h0, 4'h0);

    // SLVERR on read, then OKAY write to confirm the error does not linger
    set_waits(0, 0, 0, 0, 0);
    r_resp = 2'b10; r_data = 32'h0BAD_0BAD;
    run_req(1'b0, 1'b1, 32'h0000_400C, 32'h0, 4'h0);
    r_resp = 2'b00;
    run_req(1'b1, 1'b0, 32'h0000_4010, 32'hA5A5_5A5A, 4'hF);

    // wen and ren together, then back-to-back reads
    run_req(1'b1, 1'b1, 32'h0000_5000, 32'h7777_0000, 4'b1100);
    r_data = 32'h1111_1111;
    run_req(1'b0, 1'b1, 32'h0000_5004, 32'h0, 4'h0);
    r_data = 32'h2222_2222;
    run_req(1'b0, 1'b1, 32'h0000_5008, 32'h0, 4'h0);

    // reset while waiting in the read-data phase
    set_waits(0, 0, 0, 0, 8);
    exp_ar_q.push_back(32'h0000_6000);
    dmem_ren = 1'b1; dmem_addr = 32'h0000_6000;
    n = 0;
    while (!rready_o && n < 50) begin @(negedge ACLK); n++; end
    check("reached_read_data", 64'(rready_o), 64'd1);
    @(posedge ACLK); #1;
    ARESETn = 1'b0; dmem_ren = 1'b0;
    #1;
    check("midrst_valids", 64'({awvalid_o, wvalid_o, arvalid_o}), 64'd0);
    check("midrst_readies", 64'({bready_o, rready_o}), 64'd0);
    check("midrst_rdata", 64'(dmem_rdata), 64'd0);
    check("midrst_state", 64'(dbg_state_o), 64'(S_IDLE));
    model_rdata = '0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1; stall_cnt = 0;
    @(posedge ACLK); #1;
    set_waits(0, 0, 0, 0, 0);
    r_data = 32'h3333_4444;
    run_req(1'b0, 1'b1, 32'h0000_6000, 32'h0, 4'h0);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      b_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
      r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
      r_data = $urandom;
      a = $urandom & 32'hFFFF_FFFC;
      repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
      run_req(kind >= 2, kind != 2, a, $urandom, 4'($urandom_range(1, 15)));
    end

    repeat (4) @(posedge ACLK);
    #1;
    check("leftover_expectations",
          64'(exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_axi_master.md
Name: dmem_axi_master

Overview:
- Bridges the CPU's single-cycle DMEM request interface (addr/ren/wen/wstrb/wdata/rdata) to an AXI4 master port, used as Master 1 on the interconnect.
- Issues one single-beat transaction per request and holds the pipeline through global_stall_en until the response returns.
- Sits directly downstream of the CPU MEM stage. Its stall output is ORed into the CPU global_stall_en.

Parameters:
- ID_VAL, 4'd1, constant AWID/ARID driven on every transaction.
- ADDR_W, 32, address width; equals XLEN.
- DATA_W, 32, data width; equals AXI_DATA_BITS.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- dmem_addr  in  ADDR_W  request address from CPU MEM stage
- dmem_ren  in  1  read request, level, held while stalled
- dmem_wen  in  1  write request, level, held while stalled
- dmem_wstrb  in  DATA_W/8  byte strobes
- dmem_wdata  in  DATA_W  write data
- dmem_rdata  out  DATA_W  read data returned to CPU
- stall_o  out  1  pipeline stall request
- bus_err_o  out  1  one-cycle pulse on non-OKAY BRESP/RRESP
- aw_o  out  axi_aw_t  {id,addr,len,size,burst}
- awvalid_o  out  1
- awready_i  in  1
- w_o  out  axi_w_t  {data,strb,last}
- wvalid_o  out  1
- wready_i  in  1
- b_i  in  axi_b_t  {id,resp}
- bvalid_i  in  1
- bready_o  out  1
- ar_o  out  axi_ar_t  {id,addr,len,size,burst}
- arvalid_o  out  1
- arready_i  in  1
- r_i  in  axi_r_t  {id,data,resp,last}
- rvalid_i  in  1
- rready_o  out  1

Behaviour:
Reset values (ARESETn low, async):
- state = IDLE.
- All valid and ready outputs = 0.
- dmem_rdata = 0, bus_err_o = 0, payload registers = 0.
- Reset mid-transaction abandons the transaction; no valid is held after reset.

States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.

IDLE:
- On dmem_wen: latch addr/wdata/wstrb into the payload registers, go to WR_ADDR_DATA.
- Else on dmem_ren: latch addr, go to RD_ADDR.
- If wen and ren are both high, the write wins.

WR_ADDR_DATA:
- awvalid_o and wvalid_o are both 1 on entry.
- Each valid drops independently after its own handshake, tracked by aw_done/w_done flags.
- When both handshakes have completed (same or different cycles), go to WR_RESP.

WR_RESP:
- bready_o = 1.
- On bvalid_i: go to DONE; flag an error if resp != OKAY.

RD_ADDR:
- arvalid_o = 1.
- On arready_i: go to RD_DATA.

RD_DATA:
- rready_o = 1.
- On rvalid_i: capture r_i.data into dmem_rdata, flag an error if resp != OKAY, go to DONE.

DONE:
- Lasts one cycle, then IDLE unconditionally.
- This lets the CPU advance past the held request, so the same request is never reissued.

Signal rules:
- stall_o = (dmem_ren | dmem_wen) & (state != DONE). Combinational; high in IDLE the cycle the request first appears.
- dmem_rdata holds its value until the next read completes. Writes do not change it.
- bus_err_o = 1 only in DONE when an error was flagged.
- AXI: a valid never deasserts before its ready; the payload is stable while valid is high.
- Constant fields: len = 0, size = 3'b010, burst = INCR (2'b01), w.last = 1, id = ID_VAL.
- Response IDs are not checked (single outstanding transaction).
- Zero-wait slave latency is 3 cycles from request to release; each slave wait cycle adds 1.
  - Read: stall high in cycles 0–2, dmem_rdata valid in cycle 3.
  - Write: stall high in cycles 0–2.

Decomposition:
- AXI_define package gains:
  - axi_aw_t, axi_w_t, axi_b_t, axi_ar_t, axi_r_t.
  - RESP_OKAY, BURST_INCR, SIZE_WORD.
  - dmem_axi_state_e.
- No sub-module. The FSM and payload registers stay in one module.

Test Plan:
- Read, zero-wait slave: dmem_ren=1, addr=0x0000_1004, RDATA=0xDEAD_BEEF, RRESP=OKAY → ARADDR=0x1004, ARLEN=0, ARSIZE=2; stall_o high 3 cycles; dmem_rdata=0xDEAD_BEEF in DONE; bus_err_o=0.
- Write with WREADY 2 cycles after AWREADY: wen=1, addr=0x2000, wdata=0x1234_5678, wstrb=4'b0011 → AW handshake first, WVALID held until WREADY, BREADY only after both handshakes; stall released in the cycle after BVALID; dmem_rdata unchanged.
- Slave stalls ARREADY low 5 cycles → ARVALID and ARADDR stable all 5 cycles; stall_o high for 8 cycles total.
- RRESP=SLVERR (2'b10) → bus_err_o pulses exactly one cycle in DONE; FSM returns to IDLE.
- ARESETn asserted during RD_DATA → all valids/readies and dmem_rdata are 0 immediately; the next dmem_ren starts a fresh AR.
- wen and ren high together, then back-to-back reads → write issued with no AR; each read issues exactly one AR (no duplicate AR while dmem_ren is held during DONE).
